// File: rtl/ro_readout_pkg.sv
// Shared types and constants for the ring-oscillator count readout block.
package ro_readout_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_MEASURE = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_SEND    = 3'd4
   } state_t;

   localparam logic [7:0] HEADER_DEF  = 8'hA5;
   localparam int         FRAME_BYTES = 18;
   localparam int         COUNT_W     = 32;
   localparam int         IDX_W       = 5;
   localparam int         CAP_W       = 4 * COUNT_W;

   // XOR of every byte in the packed capture vector (frame checksum).
   function automatic logic [7:0] xor_bytes(input logic [CAP_W-1:0] v);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < CAP_W / 8; i++) begin
         acc ^= v[8*i +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/ro_frame_serializer.sv
// Captures the four counts and streams the 18-byte frame over valid/ready.
module ro_frame_serializer
   import ro_readout_pkg::*;
#(
   parameter logic [7:0] HEADER = HEADER_DEF
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [COUNT_W-1:0] inv_count,
   input  logic [COUNT_W-1:0] nand_count,
   input  logic [COUNT_W-1:0] nor_count,
   input  logic [COUNT_W-1:0] div_count,
   input  logic               tx_ready,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   output logic               last_xfer
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   logic [CAP_W-1:0] cap;
   logic [7:0]       chk;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [7:0]       frame_byte [2**IDX_W];
   logic             xfer;

   assign xfer      = tx_valid & tx_ready;
   assign last_xfer = xfer & (idx == LAST_IDX);
   assign idx_nxt   = idx + IDX_W'(1);

   // Byte at each frame position: header, 16 count bytes MSB-first, checksum.
   always_comb begin
      for (int i = 0; i < 2**IDX_W; i++) begin
         frame_byte[i] = '0;
      end
      frame_byte[0] = HEADER;
      for (int k = 0; k < CAP_W / 8; k++) begin
         frame_byte[k+1] = cap[CAP_W-1-8*k -: 8];
      end
      frame_byte[FRAME_BYTES-1] = chk;
   end

   // Capture on load, then advance one byte per accepted transfer; hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap      <= '0;
         chk      <= '0;
         idx      <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else if (load) begin
         cap      <= {inv_count, nand_count, nor_count, div_count};
         chk      <= xor_bytes({inv_count, nand_count, nor_count, div_count});
         idx      <= '0;
         tx_valid <= 1'b1;
         tx_data  <= HEADER;
      end else if (xfer) begin
         if (idx == LAST_IDX) begin
            idx      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
         end else begin
            idx     <= idx_nxt;
            tx_data <= frame_byte[idx_nxt];
         end
      end
   end

endmodule

// File: rtl/ro_count_readout.sv
// Measurement sequencer: clears the frequency counter, opens the count
// window, captures the counts and hands them to the frame serializer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; counter held in clear
// ST_CLEAR   | read_data low for CLEAR_CYCLES to reset the counter
// ST_MEASURE | read_data high for WINDOW_CYCLES while the counter runs
// ST_CAPTURE | read_data still high; counts latched into the serializer
// ST_SEND    | counter cleared again; frame bytes streaming out
module ro_count_readout
   import ro_readout_pkg::*;
#(
   parameter int unsigned CLEAR_CYCLES  = 16,
   parameter int unsigned WINDOW_CYCLES = 100010,
   parameter logic [7:0]  HEADER        = HEADER_DEF
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COUNT_W-1:0] inv_count,
   input  logic [COUNT_W-1:0] nand_count,
   input  logic [COUNT_W-1:0] nor_count,
   input  logic [COUNT_W-1:0] div_count,
   output logic               read_data,
   output logic [7:0]         tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               busy,
   output logic               done
);

   localparam int unsigned TMR_MAX = (CLEAR_CYCLES > WINDOW_CYCLES) ? CLEAR_CYCLES : WINDOW_CYCLES;
   localparam int          TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] CLEAR_LOAD  = TMR_W'(CLEAR_CYCLES - 1);
   localparam logic [TMR_W-1:0] WINDOW_LOAD = TMR_W'(WINDOW_CYCLES - 1);

   state_t           state;
   logic [TMR_W-1:0] tmr;
   logic [1:0]       rst_sync;
   logic             run_ok;
   logic             load;
   logic             last_xfer;

   // start is only honoured once the reset release has passed through two flops.
   assign run_ok = rst_sync[1];
   assign load   = (state == ST_CAPTURE);

   // Reset-release synchroniser: asserts immediately, deasserts after two edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   // Sequencer with down-counting phase timer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         tmr       <= '0;
         read_data <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start && run_ok) begin
                  state     <= ST_CLEAR;
                  tmr       <= CLEAR_LOAD;
                  busy      <= 1'b1;
                  read_data <= 1'b0;
               end
            end
            ST_CLEAR: begin
               if (tmr == '0) begin
                  state     <= ST_MEASURE;
                  tmr       <= WINDOW_LOAD;
                  read_data <= 1'b1;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            ST_MEASURE: begin
               if (tmr == '0) begin
                  state <= ST_CAPTURE;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            ST_CAPTURE: begin
               state     <= ST_SEND;
               read_data <= 1'b0;
            end
            ST_SEND: begin
               if (last_xfer) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               read_data <= 1'b0;
            end
         endcase
      end
   end

   ro_frame_serializer #(
      .HEADER (HEADER)
   ) u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .inv_count  (inv_count),
      .nand_count (nand_count),
      .nor_count  (nor_count),
      .div_count  (div_count),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .last_xfer  (last_xfer)
   );

endmodule

// File: tb/tb_ro_count_readout.sv
// Self-checking bench for ro_count_readout with a cycle-level behavioural model.
module tb_ro_count_readout;

   localparam int CLR    = 4;
   localparam int WIN    = 20;
   // Cycles after start: 0..CLR-1 clear, CLR..CLR+WIN-1 window, CLR+WIN capture.
   localparam int SEND_T = CLR + WIN + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        tx_ready = 1'b1;
   logic [31:0] inv_count = '0;
   logic [31:0] nand_count = '0;
   logic [31:0] nor_count = '0;
   logic [31:0] div_count = '0;
   logic        read_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en = 1'b0;
   int n_done = 0;
   logic [7:0]   rx_q [$];
   logic [143:0] exp_frame = '0;

   // Header, 01020304, 0A0B0C0D, 00000000, FFFFFFFF, then XOR of the sixteen
   // count bytes: (01^02^03^04)=04, (0A^0B^0C^0D)=00, zeros, (FF x4)=00 -> 04.
   logic [7:0] lit_frame [18] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C,
                                  8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF,
                                  8'hFF, 8'h04};

   ro_count_readout #(
      .CLEAR_CYCLES  (CLR),
      .WINDOW_CYCLES (WIN),
      .HEADER        (8'hA5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .inv_count  (inv_count),
      .nand_count (nand_count),
      .nor_count  (nor_count),
      .div_count  (div_count),
      .read_data  (read_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole frame as a flat byte string, position 0 in the top byte.
   function automatic logic [143:0] build_frame(input logic [31:0] a, input logic [31:0] b,
                                                input logic [31:0] c, input logic [31:0] d);
      logic [127:0] cnt;
      logic [7:0]   x;
      cnt = {a, b, c, d};
      x   = 8'h00;
      for (int i = 0; i < 16; i++) x ^= cnt[8*i +: 8];
      return {8'hA5, cnt, x};
   endfunction

   // Behavioural model: elapsed cycles since an accepted start and position in the frame.
   logic         m_busy, m_done;
   int           m_t, m_pos;
   logic [143:0] m_frame;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_t     <= 0;
         m_pos   <= 0;
         m_frame <= '0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy <= 1'b1;
               m_t    <= 0;
               m_pos  <= 0;
            end
         end else if (m_t < SEND_T) begin
            m_t <= m_t + 1;
            if (m_t == SEND_T - 1)
               m_frame <= build_frame(inv_count, nand_count, nor_count, div_count);
         end else if (tx_ready) begin
            if (m_pos == 17) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
            end else begin
               m_pos <= m_pos + 1;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("read_data", 32'(read_data), 32'(m_busy && m_t >= CLR && m_t < SEND_T));
         check("tx_valid", 32'(tx_valid), 32'(m_busy && m_t == SEND_T));
         check("done", 32'(done), 32'(m_done));
         if (m_busy && m_t == SEND_T)
            check("tx_data", 32'(tx_data), 32'(m_frame[8*(17-m_pos) +: 8]));
      end
   end

   // Collect transferred bytes and done pulses.
   always @(negedge clk) begin
      if (rst_n && tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (done) n_done++;
   end

   task automatic set_counts(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
      inv_count  = a;
      nand_count = b;
      nor_count  = c;
      div_count  = d;
   endtask

   task automatic pulse_start();
      rx_q.delete();
      n_done    = 0;
      exp_frame = build_frame(inv_count, nand_count, nor_count, div_count);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_bytes(input int nbytes, input string name);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         if (rx_q.size() >= nbytes) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, 32'(ok), 32'd1);
   endtask

   task automatic wait_frame(input bit rnd_ready, input bit scramble, input bit extra_start);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         if (n_done != 0) begin
            seen = 1'b1;
            break;
         end
         tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (scramble && m_busy && m_t == SEND_T)
            set_counts($urandom, $urandom, $urandom, $urandom);
         start = (extra_start && m_busy && m_t < SEND_T - 1) ? 1'($urandom_range(0, 2) == 0) : 1'b0;
      end
      start    = 1'b0;
      tx_ready = 1'b1;
      check("frame_done_seen", 32'(seen), 32'd1);
      repeat (30) @(posedge clk);
      #1;
      check("done_pulses", 32'(n_done), 32'd1);
      check("frame_len", 32'(rx_q.size()), 32'd18);
      for (int i = 0; i < 18 && i < rx_q.size(); i++)
         check("frame_byte", 32'(rx_q[i]), 32'(exp_frame[8*(17-i) +: 8]));
   endtask

   task automatic check_literal_frame();
      for (int i = 0; i < 18 && i < rx_q.size(); i++)
         check("literal_byte", 32'(rx_q[i]), 32'(lit_frame[i]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      check("rst_read_data", 32'(read_data), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Directed frame: read_data waveform and literal bytes at full rate.
      set_counts(32'h01020304, 32'h0A0B0C0D, 32'h00000000, 32'hFFFFFFFF);
      pulse_start();
      for (int t = 0; t <= SEND_T; t++) begin
         @(negedge clk);
         check("rd_pattern", 32'(read_data), 32'(t >= CLR && t < SEND_T));
         if (t == 0) check("busy_after_start", 32'(busy), 32'd1);
      end
      wait_frame(1'b0, 1'b0, 1'b0);
      check_literal_frame();

      // Sink stalls for five cycles while the third byte is presented.
      pulse_start();
      wait_bytes(2, "reach_byte3");
      tx_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", 32'(tx_valid), 32'd1);
         check("stall_data", 32'(tx_data), 32'h02);
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
      wait_frame(1'b0, 1'b0, 1'b0);
      check_literal_frame();

      // Reset while byte 7 is on the bus.
      set_counts($urandom, $urandom, $urandom, $urandom);
      pulse_start();
      wait_bytes(6, "reach_byte7");
      #2 rst_n = 1'b0;
      #1;
      check("abort_tx_valid", 32'(tx_valid), 32'd0);
      check("abort_read_data", 32'(read_data), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_tx_data", 32'(tx_data), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("idle_after_reset", 32'(busy), 32'd0);
      set_counts($urandom, $urandom, $urandom, $urandom);
      pulse_start();
      wait_frame(1'b0, 1'b0, 1'b0);
      if (rx_q.size() > 0) check("first_byte_header", 32'(rx_q[0]), 32'hA5);
      else check("first_byte_header", 32'(rx_q.size()), 32'd18);

      // Inputs change during SEND with a random sink.
      set_counts($urandom, $urandom, $urandom, $urandom);
      pulse_start();
      wait_frame(1'b1, 1'b1, 1'b0);

      // Extra start requests while busy.
      set_counts($urandom, $urandom, $urandom, $urandom);
      pulse_start();
      wait_frame(1'b0, 1'b0, 1'b1);

      // Fully randomised frames.
      for (int f = 0; f < 6; f++) begin
         set_counts($urandom, $urandom, $urandom, $urandom);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         pulse_start();
         wait_frame(1'b1, 1'b1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
